// File: rtl/ptp_ts_queue.sv
// ptp_ts_queue: latches the RTC time at every packet SOP and, when the PTP
// parser flags an event message for that packet, pushes
// {seconds, nanoseconds, ptp_infor} into a synchronous FIFO. The host pops
// one entry per cycle; data appears one cycle after the pop request.
//
// Handshake: q_rd_en is a request, not a valid/ready pair. A pop is taken
// only when the queue is not empty; q_rd_valid pulses for exactly one cycle
// one clock later and q_rd_data holds its value until the next pop.
//
// Build option: define PTP_TS_QUEUE_OVERWRITE_EN to make a push into a full
// queue (with no simultaneous pop) overwrite the oldest entry instead of
// dropping the new one. The overflow counter counts either case.
module ptp_ts_queue #(
    parameter int ADDR_W   = 4,
    parameter int TAIL_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              int_valid,
    input  logic              int_sop,
    input  logic              int_eop,
    input  logic              ptp_found,
    input  logic [31:0]       ptp_infor,
    input  logic [47:0]       rtc_sec,
    input  logic [31:0]       rtc_ns,
    input  logic              q_rd_en,
    input  logic              q_clr,
    output logic [111:0]      q_rd_data,
    output logic              q_rd_valid,
    output logic [ADDR_W:0]   q_count,
    output logic              q_empty,
    output logic              q_full,
    output logic [7:0]        q_ovf_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int TW    = (TAIL_CYC > 1) ? $clog2(TAIL_CYC) : 1;
    localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_IN_PKT = 2'd1,
        S_TAIL   = 2'd2
    } state_t;

    // Capture FSM state
    state_t          state, state_nxt;
    logic [TW-1:0]   tail_cnt, tail_nxt;
    logic            eop_pend, eop_pend_nxt;

    // Per-packet context
    logic [79:0]     ts_hold;
    logic            pushed;
    logic            found_d1;

    // FIFO state
    logic [111:0]    mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;

    logic sop, eop, found_rise, push_req;
    logic do_pop, push_ok, mem_we, ovf_event;

    assign sop        = int_valid && int_sop;
    assign eop        = int_valid && int_eop;
    assign found_rise = ptp_found && !found_d1;
    assign push_req   = found_rise && (state == S_IN_PKT || state == S_TAIL) && !pushed;

    assign q_empty = (q_count == '0);
    assign q_full  = (q_count == (ADDR_W + 1)'(DEPTH));

    // A pop only happens when something is stored; a push lands in the array
    // when there is room, or when a pop frees the slot in the same cycle.
    assign do_pop    = q_rd_en && !q_empty;
    assign push_ok   = push_req && (!q_full || do_pop);
    assign ovf_event = push_req && q_full && !do_pop;
`ifdef PTP_TS_QUEUE_OVERWRITE_EN
    assign mem_we    = push_ok || ovf_event;
`else
    assign mem_we    = push_ok;
`endif

    // Capture FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            tail_cnt <= '0;
            eop_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            tail_cnt <= tail_nxt;
            eop_pend <= eop_pend_nxt;
        end
    end

    // Capture FSM next state: SOP restarts from any state; an EOP seen on the
    // SOP beat itself is remembered and acted on one cycle later.
    always_comb begin
        state_nxt    = state;
        tail_nxt     = tail_cnt;
        eop_pend_nxt = eop_pend;
        if (sop) begin
            state_nxt    = S_IN_PKT;
            tail_nxt     = '0;
            eop_pend_nxt = eop;
        end else begin
            case (state)
                S_IN_PKT: begin
                    if (eop || eop_pend) begin
                        state_nxt    = S_TAIL;
                        tail_nxt     = '0;
                        eop_pend_nxt = 1'b0;
                    end
                end
                S_TAIL: begin
                    if (tail_cnt == TAIL_LAST) begin
                        state_nxt = S_IDLE;
                    end else begin
                        tail_nxt = tail_cnt + TW'(1);
                    end
                end
                default: begin
                    eop_pend_nxt = 1'b0;
                end
            endcase
        end
    end

    // Per-packet timestamp latch and push-once bookkeeping; a new SOP wins
    // over a push in the same cycle for the pushed flag, but the push still
    // uses the previous timestamp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_hold  <= '0;
            pushed   <= 1'b0;
            found_d1 <= 1'b0;
        end else begin
            found_d1 <= ptp_found;
            if (sop) begin
                ts_hold <= {rtc_sec, rtc_ns};
                pushed  <= 1'b0;
            end else if (push_req) begin
                pushed  <= 1'b1;
            end
        end
    end

    // FIFO storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (mem_we && !q_clr) begin
            mem[wr_ptr] <= {ts_hold, ptp_infor};
        end
    end

    // FIFO pointers, occupancy, read port and overflow counter; q_clr
    // overrides any push or pop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_count    <= '0;
            q_rd_data  <= '0;
            q_rd_valid <= 1'b0;
            q_ovf_cnt  <= '0;
        end else if (q_clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_count    <= '0;
            q_rd_valid <= 1'b0;
            q_ovf_cnt  <= '0;
        end else begin
            q_rd_valid <= do_pop;
            if (do_pop) begin
                q_rd_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + ADDR_W'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (ovf_event) begin
                if (q_ovf_cnt != 8'hFF) begin
                    q_ovf_cnt <= q_ovf_cnt + 8'd1;
                end
`ifdef PTP_TS_QUEUE_OVERWRITE_EN
                // Oldest entry is replaced: both pointers step, count stays full.
                wr_ptr <= wr_ptr + ADDR_W'(1);
                rd_ptr <= rd_ptr + ADDR_W'(1);
`endif
            end
            if (push_ok && !do_pop) begin
                q_count <= q_count + (ADDR_W + 1)'(1);
            end else if (!push_ok && do_pop) begin
                q_count <= q_count - (ADDR_W + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_ptp_ts_queue.sv
// Directed bench for ptp_ts_queue with a queue-based scoreboard of expected
// popped entries and a small occupancy/overflow model.
module tb_ptp_ts_queue;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic          clk;
    logic          rst;
    logic          int_valid;
    logic          int_sop;
    logic          int_eop;
    logic          ptp_found;
    logic [31:0]   ptp_infor;
    logic [47:0]   rtc_sec;
    logic [31:0]   rtc_ns;
    logic          q_rd_en;
    logic          q_clr;
    logic [111:0]  q_rd_data;
    logic          q_rd_valid;
    logic [ADDR_W:0] q_count;
    logic          q_empty;
    logic          q_full;
    logic [7:0]    q_ovf_cnt;

    ptp_ts_queue #(.ADDR_W(ADDR_W), .TAIL_CYC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .int_valid  (int_valid),
        .int_sop    (int_sop),
        .int_eop    (int_eop),
        .ptp_found  (ptp_found),
        .ptp_infor  (ptp_infor),
        .rtc_sec    (rtc_sec),
        .rtc_ns     (rtc_ns),
        .q_rd_en    (q_rd_en),
        .q_clr      (q_clr),
        .q_rd_data  (q_rd_data),
        .q_rd_valid (q_rd_valid),
        .q_count    (q_count),
        .q_empty    (q_empty),
        .q_full     (q_full),
        .q_ovf_cnt  (q_ovf_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard
    logic [111:0] exp_q[$];
    int exp_ovf = 0;
    int n_cmp   = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [111:0] obs, input logic [111:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, q_count, exp_q.size());
        check({tag, "_empty"}, q_empty, (exp_q.size() == 0));
        check({tag, "_full"},  q_full,  (exp_q.size() == DEPTH));
        check({tag, "_ovf"},   q_ovf_cnt, exp_ovf);
    endtask

    // Model of one accepted parser push
    task automatic model_push(input logic [111:0] e);
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(e);
        end else begin
            if (exp_ovf < 255) exp_ovf++;
`ifdef PTP_TS_QUEUE_OVERWRITE_EN
            void'(exp_q.pop_front());
            exp_q.push_back(e);
`endif
        end
    endtask

    // SOP beat; RTC moves on afterwards so only the latched value is correct
    task automatic send_sop(input logic [47:0] s, input logic [31:0] n);
        rtc_sec   = s;
        rtc_ns    = n;
        int_valid = 1'b1;
        int_sop   = 1'b1;
        tick();
        int_valid = 1'b0;
        int_sop   = 1'b0;
        rtc_sec   = s + 48'h55;
        rtc_ns    = n + 32'h77;
    endtask

    task automatic send_eop();
        int_valid = 1'b1;
        int_eop   = 1'b1;
        tick();
        int_valid = 1'b0;
        int_eop   = 1'b0;
    endtask

    // One-cycle ptp_found pulse; the push (if any) happens at this edge
    task automatic raise_found(input logic [31:0] inf, input logic [79:0] ts, input bit expect_push);
        ptp_found = 1'b1;
        ptp_infor = inf;
        tick();
        ptp_found = 1'b0;
        if (expect_push) model_push({ts, inf});
    endtask

    task automatic pop_check(input string tag);
        logic [111:0] e;
        q_rd_en = 1'b1;
        tick();
        q_rd_en = 1'b0;
        e = exp_q.pop_front();
        check({tag, "_valid"}, q_rd_valid, 1'b1);
        check({tag, "_data"},  q_rd_data,  e);
        tick();
        check({tag, "_strobe_end"}, q_rd_valid, 1'b0);
        check({tag, "_hold"}, q_rd_data, e);
    endtask

    task automatic full_packet(input int i);
        logic [47:0] s;
        logic [31:0] n;
        s = 48'h100 + 48'(i);
        n = 32'(i * 10 + 3);
        send_sop(s, n);
        tick();
        raise_found(32'h3000_0000 + 32'(i), {s, n}, 1'b1);
        send_eop();
        tick(); tick(); tick();
    endtask

    initial begin
        logic [111:0] e;
        rst = 1'b1;
        int_valid = 0; int_sop = 0; int_eop = 0;
        ptp_found = 0; ptp_infor = '0;
        rtc_sec = '0; rtc_ns = '0;
        q_rd_en = 0; q_clr = 0;

        // Reset state
        tick(); tick();
        check_status("reset");
        check("reset_rd_valid", q_rd_valid, 1'b0);
        check("reset_rd_data",  q_rd_data,  '0);
        rst = 1'b0;
        tick();

        // Pop on empty queue: no strobe
        q_rd_en = 1'b1;
        tick();
        q_rd_en = 1'b0;
        check("pop_empty_valid", q_rd_valid, 1'b0);
        check_status("pop_empty");

        // 1: basic capture, push 12 cycles later, pop
        send_sop(48'h1, 32'h100);
        for (int k = 0; k < 11; k++) begin
            rtc_ns = rtc_ns + 32'd8;
            tick();
        end
        raise_found(32'h1ABC0007, {48'h1, 32'h100}, 1'b1);
        check_status("t1_push");
        send_eop();
        tick(); tick(); tick();
        pop_check("t1_pop");
        check_status("t1_after_pop");

        // 2a: rise one cycle after EOP is still credited
        send_sop(48'h2, 32'h200);
        tick();
        send_eop();
        raise_found(32'h2000_0001, {48'h2, 32'h200}, 1'b1);
        check_status("t2a_push");
        tick(); tick();
        pop_check("t2a_pop");

        // 2b: rise three cycles after EOP is ignored
        send_sop(48'h3, 32'h300);
        tick();
        send_eop();
        tick(); tick();
        raise_found(32'h2000_0002, {48'h3, 32'h300}, 1'b0);
        check_status("t2b_nopush");
        tick();

        // 3: seventeen packets with no pops overflow by one
        for (int i = 1; i <= 17; i++) full_packet(i);
        check_status("t3_full");
        check("t3_count16", q_count, 16);
        check("t3_ovf1", q_ovf_cnt, 1);
        pop_check("t3_first_pop");

        // Flush
        q_clr = 1'b1;
        tick();
        q_clr = 1'b0;
        exp_q.delete();
        exp_ovf = 0;
        check_status("clr");

        // 5a: full queue, push and pop in the same cycle
        for (int i = 20; i < 36; i++) full_packet(i);
        check_status("t5_full");
        send_sop(48'hAA, 32'hBB);
        tick();
        q_rd_en   = 1'b1;
        ptp_found = 1'b1;
        ptp_infor = 32'h5555_0001;
        tick();
        q_rd_en   = 1'b0;
        ptp_found = 1'b0;
        e = exp_q.pop_front();
        exp_q.push_back({48'hAA, 32'hBB, 32'h5555_0001});
        check("t5_pp_valid", q_rd_valid, 1'b1);
        check("t5_pp_data", q_rd_data, e);
        check_status("t5_pushpop");
        send_eop();
        tick(); tick(); tick();

        // 5b: clear with a push in the same cycle
        send_sop(48'hCC, 32'hDD);
        tick();
        q_clr     = 1'b1;
        ptp_found = 1'b1;
        ptp_infor = 32'h5555_0002;
        tick();
        q_clr     = 1'b0;
        ptp_found = 1'b0;
        exp_q.delete();
        exp_ovf = 0;
        check_status("t5_clr_push");
        check("t5_clr_valid", q_rd_valid, 1'b0);
        send_eop();
        tick(); tick(); tick();

        // 4: found rise on the same beat as the next SOP
        send_sop(48'h44, 32'h4400);
        tick(); tick();
        rtc_sec   = 48'h45;
        rtc_ns    = 32'h4500;
        int_valid = 1'b1;
        int_sop   = 1'b1;
        ptp_found = 1'b1;
        ptp_infor = 32'h4000_0001;
        tick();
        int_valid = 1'b0;
        int_sop   = 1'b0;
        ptp_found = 1'b0;
        rtc_sec   = 48'h99;
        model_push({48'h44, 32'h4400, 32'h4000_0001});
        check_status("t4_push_old");
        tick();
        raise_found(32'h4000_0002, {48'h45, 32'h4500}, 1'b1);
        check_status("t4_push_new");
        pop_check("t4_pop_old");
        pop_check("t4_pop_new");
        send_eop();
        tick(); tick(); tick();

        // 6: reset mid-packet
        send_sop(48'h60, 32'h600);
        raise_found(32'h6000_0001, {48'h60, 32'h600}, 1'b1);
        check_status("t6_pre");
        send_sop(48'h61, 32'h610);
        tick();
        rst = 1'b1;
        #2;
        exp_q.delete();
        exp_ovf = 0;
        check_status("t6_rst");
        check("t6_rst_valid", q_rd_valid, 1'b0);
        check("t6_rst_data",  q_rd_data,  '0);
        tick();
        rst = 1'b0;
        tick();
        raise_found(32'h6000_0002, {48'h61, 32'h610}, 1'b0);
        check_status("t6_after");
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ptp_ts_queue.md
Name: ptp_ts_queue

Overview:
Downstream companion of the PTP packet parser in the TSU.
- Latches the RTC time at each packet SOP.
- When the parser flags a PTP event message for that packet, pushes {seconds, nanoseconds, ptp_infor} into a synchronous FIFO.
- Host/register logic pops entries through a simple read handshake.
- Single clock domain; one instance per RX or TX direction.

Parameters:
ADDR_W, 4, FIFO address width; depth = 2**ADDR_W entries.
TAIL_CYC, 2, cycles after EOP during which a ptp_found rise is still credited to the finished packet.

Ports:
clk  in  1  clock
rst  in  1  reset
int_valid  in  1  data-beat qualifier, same stream the parser sees
int_sop  in  1  start of packet, qualified by int_valid
int_eop  in  1  end of packet, qualified by int_valid
ptp_found  in  1  parser flag; rises once per PTP event packet, cleared by parser on next SOP
ptp_infor  in  32  parser info {msgid[31:28], cksum[27:16], seqid[15:0]}, valid while ptp_found=1
rtc_sec  in  48  RTC seconds
rtc_ns  in  32  RTC nanoseconds
q_rd_en  in  1  pop request, one entry per cycle
q_clr  in  1  synchronous queue flush
q_rd_data  out  112  {sec[111:64], ns[63:32], infor[31:0]}
q_rd_valid  out  1  one-cycle strobe, q_rd_data valid
q_count  out  ADDR_W+1  occupied entries
q_empty  out  1  q_count==0
q_full  out  1  q_count==2**ADDR_W
q_ovf_cnt  out  8  dropped-entry counter, saturating

Behaviour:
- Reset and clock: rst is asynchronous, active-high; clock is clk.
- Reset values: all outputs 0 except q_empty=1. FSM in IDLE; ts_hold=0; pushed=0; found_d1=0.
- Timestamp capture:
  - On int_valid && int_sop: ts_hold <= {rtc_sec, rtc_ns}, pushed <= 0, FSM -> IN_PKT.
  - Applies from any state; an in-flight packet is abandoned without a push.
- found_d1 is ptp_found delayed one cycle; found_rise = ptp_found && !found_d1.
- FSM states:
  - IDLE: no packet active.
  - IN_PKT: int_valid && int_eop -> TAIL with tail_cnt=0. SOP and EOP on the same beat: stay IN_PKT after the capture, then go to TAIL on the next cycle.
  - TAIL: tail_cnt increments each cycle. At tail_cnt==TAIL_CYC-1 -> IDLE. SOP -> IN_PKT.
- Push:
  - push_req = found_rise && state in {IN_PKT, TAIL} && !pushed.
  - Entry = {ts_hold, ptp_infor}; written at the next clock edge; pushed <= 1.
  - At most one push per packet.
  - found_rise in the same cycle as a new SOP: push uses the old ts_hold. Both the push and the capture happen.
  - found_rise in IDLE is ignored.
- Latency: found_rise at cycle t -> q_empty=0 and q_count updated at t+1.
- Pop:
  - q_rd_en && !q_empty at cycle t -> q_rd_data, q_rd_valid=1 at t+1; q_rd_data holds its value afterwards.
  - q_rd_en while empty: ignored, no strobe.
- Simultaneous events:
  - Push and pop together: count unchanged; legal when full (pop frees a slot first).
  - Push when full without pop: entry dropped, q_ovf_cnt +1, saturating at 255.
- q_clr: pointers, q_count and q_ovf_cnt -> 0, q_rd_valid -> 0. Overrides push and pop in the same cycle. Capture FSM unaffected.
- Pointers are ADDR_W bits and wrap naturally. q_count tracks occupancy. FIFO storage needs no reset.
- rst mid-packet: everything returns to reset values; the current packet produces no push even if ptp_found later rises.

Optional Feature:
Macro PTP_TS_QUEUE_OVERWRITE_EN.
- Defined: push into a full queue without a simultaneous pop overwrites the oldest entry (read pointer advances). q_count stays at full; q_ovf_cnt still increments.
- Not defined: the new entry is dropped as specified above.

Test Plan:
1. SOP with rtc={48'h1, 32'h100}; ptp_found rises 12 cycles later with infor=32'h1ABC0007 -> q_count=1 next cycle; pop -> q_rd_data={48'h1, 32'h100, 32'h1ABC0007}, q_rd_valid for one cycle.
2. EOP, then ptp_found rises 1 cycle later (TAIL_CYC=2) -> pushed. Repeat with the rise 3 cycles after EOP -> no push, q_empty stays 1.
3. 17 PTP packets, no pops (ADDR_W=4) -> q_full=1, q_count=16, q_ovf_cnt=1. With macro: first pop returns packet 2's timestamp.
4. found_rise on the same cycle as the next SOP -> pushed entry carries the previous SOP's timestamp; new ts_hold holds the new RTC value.
5. Full queue, push and q_rd_en in the same cycle -> q_count stays 16, q_ovf_cnt=0. q_clr with push in the same cycle -> q_count=0, q_ovf_cnt=0.
6. rst asserted mid-packet after SOP -> outputs return to reset values; ptp_found rising after reset release -> no push.
